hilo_md_unit: RTL and testbench
===============================

// Module: hilo_md_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the EX stage. It produces HI/LO results for
//  MULT/MULTU/DIV/DIVU and the accumulate forms MADD/MADDU/MSUB/MSUBU.
//  It adds a start/busy/ready handshake, annul (flush) and a divide-by-zero flag.
//  EX asserts start_i, holds the pipeline via stallreq while busy_o=1, and writes hi_o/lo_o to HILO when ready_o=1.
// PARAMETERS
//  WIDTH     32  operand width; HI and LO are each WIDTH bits
//  MUL_PIPE  2   multiply pipeline depth in cycles, >=1
// PORTS
//  clk            in   1      clock, all state on rising edge
//  resetn         in   1      synchronous, active-low reset
//  start_i        in   1      request; sampled only in IDLE
//  op_i           in   3      000 MULT,001 MULTU,010 DIV,011 DIVU,100 MADD,101 MADDU,110 MSUB,111 MSUBU
//  src_a_i        in   WIDTH  rs: multiplicand or dividend
//  src_b_i        in   WIDTH  rt: multiplier or divisor
//  hi_i, lo_i     in   WIDTH  current HI/LO (accumulate ops only)
//  annul_i        in   1      abort the in-flight operation
//  busy_o         out  1      operation in flight (states MUL, DIV, FIX)
//  ready_o        out  1      one-cycle pulse; hi_o/lo_o valid
//  hi_o, lo_o     out  WIDTH  result; held until the next ready_o
//  div_by_zero_o  out  1      set with ready_o on a zero divisor; cleared at next start
// BEHAVIOUR
//  Reset: resetn=0 at an edge -> state IDLE, all counters 0, every output 0. Reset wins over all
//   other inputs, including mid-operation.
//  Cycle numbering: start_i=1 in IDLE during cycle 0. Operands, op and hi_i/lo_i are captured at
//   the end of cycle 0. Inputs are ignored afterwards.
//  FSM: IDLE -> MUL | DIV | DONE.  MUL -(MUL_PIPE cycles)-> DONE.  DIV -(WIDTH cycles)-> FIX -> DONE.
//   DONE -> IDLE unconditionally. start_i in DONE or a busy state is ignored (not queued).
//  ready_o = (state==DONE). busy_o = MUL|DIV|FIX.
//  Multiply: ready in cycle MUL_PIPE+1. 2*WIDTH-bit product; signed for even op codes, unsigned for odd.
//  Accumulate: {hi_o,lo_o} = {hi_i,lo_i} +/- product, mod 2^(2*WIDTH). Values are those captured in cycle 0.
//  Divide: restoring algorithm on magnitudes, one quotient bit per cycle. Ready in cycle WIDTH+2.
//   lo_o = quotient, hi_o = remainder.
//   Signed: quotient negated iff sign(a)^sign(b); remainder takes the sign of a (truncating).
//   Most-negative / -1 -> lo=most-negative, hi=0. No exception.
//  Divide by zero: detected at capture. IDLE -> DONE directly, so ready in cycle 1.
//   Result: lo_o = all ones, hi_o = src_a_i, div_by_zero_o=1.
//  Annul: annul_i=1 in MUL/DIV/FIX -> IDLE at the next edge. ready_o is not pulsed and hi_o/lo_o/div_by_zero_o are unchanged.
//   annul_i and start_i together in IDLE -> start ignored. annul_i in DONE has no effect; the pulse still occurs.
//  hi_o/lo_o update only on the edge that enters DONE. Between operations they hold their last value.
// TESTING (WIDTH=32, MUL_PIPE=2)
//  1 MULT a=FFFFFFFD b=00000005 -> ready cycle 3, hi=FFFFFFFF lo=FFFFFFF1; MULTU same -> hi=00000004 lo=FFFFFFF1
//  2 DIV a=FFFFFFF9 b=00000002 -> ready cycle 34, lo=FFFFFFFD hi=FFFFFFFF;
//    DIVU a=FFFFFFFF b=10 -> lo=0FFFFFFF hi=0000000F
//  3 DIVU a=5 b=0 -> ready cycle 1, lo=FFFFFFFF hi=00000005 dbz=1; next MULT 2*2 -> dbz=0 hi=0 lo=4
//  4 MADDU hi_i=0 lo_i=FFFFFFFF a=b=1 -> hi=1 lo=0; MSUB hi_i=lo_i=0 a=b=1 -> hi=lo=FFFFFFFF
//  5 DIV started, annul_i=1 in cycle 10 -> busy_o=0 from cycle 11, no ready_o, hi/lo unchanged;
//    start_i held during busy -> ignored
//  6 resetn=0 in cycle 5 of DIV -> state IDLE and all outputs 0 after that edge; new MULT afterwards completes normally

Source files
------------

// File: rtl/hilo_md_unit.sv
// Multi-cycle HI/LO multiply/divide unit: signed/unsigned multiply, multiply-accumulate and
// restoring divide, with start/busy/ready handshake, annul and divide-by-zero flag.
module hilo_md_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_PIPE = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + MUL_PIPE + 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              dbz_q, dbz_d;

  // Multiply: sign-extend to 2*WIDTH so one unsigned multiply serves both signednesses.
  logic              mul_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, product, acc_in, mul_result;

  assign mul_signed = ~op_q[0];
  assign mul_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
  assign mul_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
  assign product    = mul_a * mul_b;
  assign acc_in     = {acc_hi_q, acc_lo_q};

  always_comb begin
    mul_result = product;
    if (op_q[2]) begin
      mul_result = op_q[1] ? (acc_in - product) : (acc_in + product);
    end
  end

  // Divide: quo_q starts as the dividend magnitude and is shifted out MSB-first while
  // quotient bits shift in from the bottom.
  logic             a_neg, b_neg, in_a_neg;
  logic [WIDTH-1:0] b_mag, a_mag_in, q_fix, r_fix;
  logic [WIDTH:0]   shifted, trial;
  logic             borrow;

  assign a_neg    = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg    = ~op_q[0] & b_q[WIDTH-1];
  assign b_mag    = b_neg ? (WIDTH'(0) - b_q) : b_q;
  assign in_a_neg = ~op_i[0] & src_a_i[WIDTH-1];
  assign a_mag_in = in_a_neg ? (WIDTH'(0) - src_a_i) : src_a_i;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, b_mag};
  assign borrow   = trial[WIDTH];
  assign q_fix    = (a_neg ^ b_neg) ? (WIDTH'(0) - quo_q) : quo_q;
  assign r_fix    = a_neg ? (WIDTH'(0) - rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          op_d     = op_i;
          a_d      = src_a_i;
          b_d      = src_b_i;
          acc_hi_d = hi_i;
          acc_lo_d = lo_i;
          quo_d    = a_mag_in;
          rem_d    = '0;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          if (op_i[2:1] == 2'b01) begin
            if (src_b_i == '0) begin
              state_d = StDone;
              hi_d    = src_a_i;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end else begin
              state_d = StDiv;
            end
          end else begin
            state_d = StMul;
          end
        end
      end
      StMul: begin
        if (annul_i) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(MUL_PIPE - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = mul_result[2*WIDTH-1:WIDTH];
          lo_d    = mul_result[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~borrow};
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFix: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          hi_d    = r_fix;
          lo_d    = q_fix;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign ready_o       = (state_q == StDone);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Bench for hilo_md_unit: vector table feeding a result scoreboard, plus annul,
// start-while-busy and mid-operation reset sequences.
module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i, hi_i, lo_i;
  logic        annul_i;
  logic        busy_o, ready_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  hilo_md_unit #(.WIDTH(32), .MUL_PIPE(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start_i       (start_i),
    .op_i          (op_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .annul_i       (annul_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hin, lin, ehi, elo;
    logic        edbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && ready_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("dbz", 64'(div_by_zero_o), 64'(e.dbz));
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hin, input logic [31:0] lin,
                              input logic [31:0] ehi, input logic [31:0] elo,
                              input logic edbz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hin = hin; v.lin = lin;
    v.ehi = ehi; v.elo = elo; v.edbz = edbz; v.lat = lat;
    return v;
  endfunction

  // hold_start keeps start_i high with junk operands while busy; it must be ignored.
  task automatic run_vec(input vec_t v, input bit hold_start);
    exp_t e;
    @(negedge clk);
    op_i = v.op; src_a_i = v.a; src_b_i = v.b; hi_i = v.hin; lo_i = v.lin; start_i = 1'b1;
    e.hi = v.ehi; e.lo = v.elo; e.dbz = v.edbz; e.cyc = cyc + v.lat;
    sb_q.push_back(e);
    @(negedge clk);
    if (hold_start) begin
      op_i = 3'b011; src_a_i = 32'h1234_5678; src_b_i = 32'h0; hi_i = '1; lo_i = '1;
    end else begin
      start_i = 1'b0;
    end
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge clk);
    start_i = 1'b0;
    if (sb_q.size() != 0) begin
      check("ready_timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
  endtask

  vec_t vecs[15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [31:0] hold_hi, hold_lo;
    logic        hold_dbz;

    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
    src_a_i = '0; src_b_i = '0; hi_i = '0; lo_i = '0;

    vecs[0]  = mk(3'd0, 32'hFFFFFFFD, 32'h5, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 3);
    vecs[1]  = mk(3'd1, 32'hFFFFFFFD, 32'h5, 0, 0, 32'h00000004, 32'hFFFFFFF1, 0, 3);
    vecs[2]  = mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 0, 3);
    vecs[3]  = mk(3'd2, 32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
    vecs[4]  = mk(3'd3, 32'hFFFFFFFF, 32'h10, 0, 0, 32'h0000000F, 32'h0FFFFFFF, 0, 34);
    vecs[5]  = mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, 0, 34);
    vecs[6]  = mk(3'd2, 32'h7, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFD, 0, 34);
    vecs[7]  = mk(3'd3, 32'h5, 32'h0, 0, 0, 32'h5, 32'hFFFFFFFF, 1, 1);
    vecs[8]  = mk(3'd0, 32'h2, 32'h2, 0, 0, 32'h0, 32'h4, 0, 3);
    vecs[9]  = mk(3'd5, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 3);
    vecs[10] = mk(3'd6, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3);
    vecs[11] = mk(3'd4, 32'hFFFFFFFF, 32'h3, 32'h0, 32'hA, 32'h0, 32'h7, 0, 3);
    vecs[12] = mk(3'd7, 32'h2, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFE, 0, 3);
    vecs[13] = mk(3'd2, 32'h5, 32'h0, 0, 0, 32'h5, 32'hFFFFFFFF, 1, 1);
    vecs[14] = mk(3'd3, 32'h64, 32'h7, 0, 0, 32'h2, 32'hE, 0, 34);

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_hi", 64'(hi_o), 64'(0));
    check("rst_lo", 64'(lo_o), 64'(0));
    check("rst_dbz", 64'(div_by_zero_o), 64'(0));
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // start held through a multiply: only the first request is taken.
    run_vec(mk(3'd1, 32'h10, 32'h10, 0, 0, 32'h0, 32'h100, 0, 3), 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_queued_start", 64'(busy_o), 64'(0));
    end

    // Annul in cycle 10 of a divide; start held during busy is ignored.
    hold_hi = hi_o; hold_lo = lo_o; hold_dbz = div_by_zero_o;
    @(negedge clk);
    op_i = 3'd2; src_a_i = 32'd100; src_b_i = 32'd7; start_i = 1'b1; s = cyc;
    while (cyc != s + 10) @(negedge clk);
    check("busy_in_div", 64'(busy_o), 64'(1));
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'(0));
    check("annul_hi", 64'(hi_o), 64'(hold_hi));
    check("annul_lo", 64'(lo_o), 64'(hold_lo));
    check("annul_dbz", 64'(div_by_zero_o), 64'(hold_dbz));

    // annul together with start in idle: nothing launches.
    @(negedge clk);
    op_i = 3'd0; src_a_i = 32'd3; src_b_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_start_idle", 64'(busy_o), 64'(0));
    repeat (4) @(negedge clk);

    // Reset in cycle 5 of a divide clears everything.
    op_i = 3'd3; src_a_i = 32'hFFFF0000; src_b_i = 32'd3; start_i = 1'b1; s = cyc;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc != s + 5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_ready", 64'(ready_o), 64'(0));
    check("mid_rst_hi", 64'(hi_o), 64'(0));
    check("mid_rst_lo", 64'(lo_o), 64'(0));
    check("mid_rst_dbz", 64'(div_by_zero_o), 64'(0));
    resetn = 1'b1;
    run_vec(mk(3'd0, 32'h2, 32'h3, 0, 0, 32'h0, 32'h6, 0, 3), 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
